// File: rtl/cdc_launch_ctrl.sv
// Source-side launcher for the clk_a -> clk_b data crossing: buffers upstream words in a FIFO
// and presents each as a data_out/data_en pair with a setup cycle before and a guard gap after.
module cdc_launch_ctrl #(
  parameter int DATA_WIDTH  = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                          clk_a,
  input  logic                          arstn,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          data_en,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          busy,
  output logic [7:0]                    sent_cnt
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LW   = AW + 1;
  localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;

  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HOLD  = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t                state_r;
  logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_r;
  logic [AW-1:0]         rd_ptr_r;
  logic [LW-1:0]         level_r;
  logic [CW-1:0]         cnt_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  en_r;
  logic [7:0]            sent_r;
  logic                  ready_s;
  logic                  push_s;
  logic                  pop_s;

  assign ready_s  = (level_r != FULL_LEVEL);
  assign in_ready = ready_s;
  assign data_out = data_r;
  assign data_en  = en_r;
  assign level    = level_r;
  assign sent_cnt = sent_r;
  assign busy     = (state_r != IDLE) || (level_r != LW'(0));

  // Push/pop decisions; pops look only at the registered level, so a word is never
  // popped on the same edge that wrote it.
  always_comb begin
    push_s = in_valid && ready_s;
    pop_s  = 1'b0;
    case (state_r)
      IDLE: begin
        pop_s = (level_r != LW'(0));
      end
      GAP: begin
        if (cnt_r == GAP_LAST) begin
          pop_s = (level_r != LW'(0));
        end else begin
          pop_s = 1'b0;
        end
      end
      default: begin
        pop_s = 1'b0;
      end
    endcase
  end

  // FIFO storage; contents need no reset because level gates every read.
  always_ff @(posedge clk_a) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

  // Pointers, occupancy and the launch FSM with its registered outputs.
  always_ff @(posedge clk_a or negedge arstn) begin
    if (!arstn) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      level_r  <= LW'(0);
      state_r  <= IDLE;
      cnt_r    <= CW'(0);
      data_r   <= DATA_WIDTH'(0);
      en_r     <= 1'b0;
      sent_r   <= 8'd0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase

      case (state_r)
        IDLE: begin
          en_r <= 1'b0;
          if (pop_s) begin
            data_r  <= mem_r[rd_ptr_r];
            state_r <= SETUP;
          end
        end
        SETUP: begin
          state_r <= HOLD;
          en_r    <= 1'b1;
          cnt_r   <= CW'(0);
          sent_r  <= sent_r + 8'd1;
        end
        HOLD: begin
          if (cnt_r == HOLD_LAST) begin
            en_r    <= 1'b0;
            cnt_r   <= CW'(0);
            state_r <= GAP;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        GAP: begin
          en_r <= 1'b0;
          if (cnt_r == GAP_LAST) begin
            if (pop_s) begin
              data_r  <= mem_r[rd_ptr_r];
              state_r <= SETUP;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          en_r    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_launch_ctrl.sv
// Scoreboard bench for cdc_launch_ctrl: default instance plus a HOLD=1/GAP=1 instance;
// drivers push expected words into queues, negedge monitors pop and compare at each launch.
module tb_cdc_launch_ctrl;

  logic       clk_a = 1'b0;
  always #5 clk_a = ~clk_a;

  logic       arstn;
  logic       in_valid, in_ready, data_en, busy;
  logic [3:0] in_data, data_out;
  logic [2:0] level;
  logic [7:0] sent_cnt;

  logic       f_valid, f_ready, f_en, f_busy;
  logic [3:0] f_data, f_out;
  logic [2:0] f_level;
  logic [7:0] f_sent;

  cdc_launch_ctrl dut (
    .clk_a(clk_a), .arstn(arstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .data_out(data_out), .data_en(data_en), .level(level),
    .busy(busy), .sent_cnt(sent_cnt)
  );

  cdc_launch_ctrl #(.HOLD_CYCLES(1), .GAP_CYCLES(1)) dut_fast (
    .clk_a(clk_a), .arstn(arstn), .in_valid(f_valid), .in_ready(f_ready),
    .in_data(f_data), .data_out(f_out), .data_en(f_en), .level(f_level),
    .busy(f_busy), .sent_cnt(f_sent)
  );

  int         n_vec = 0;
  int         n_err = 0;
  logic [3:0] exp_q[$];
  logic [3:0] f_q[$];
  bit         chk_period = 1'b0;
  int         n_launch = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_a(input logic [3:0] d, output int waits);
    bit   ok;
    logic rdy;
    ok = 1'b0; waits = 0;
    in_valid = 1'b1; in_data = d;
    for (int t = 0; t < 100 && !ok; t++) begin
      rdy = in_ready;
      @(posedge clk_a);
      if (rdy) begin
        exp_q.push_back(d);
        ok = 1'b1;
      end else begin
        waits++;
      end
      @(negedge clk_a);
    end
    if (!ok) chk("push_timeout", 32'(ok), 32'd1);
  endtask

  task automatic push_f(input logic [3:0] d);
    bit   ok;
    logic rdy;
    ok = 1'b0;
    f_valid = 1'b1; f_data = d;
    for (int t = 0; t < 100 && !ok; t++) begin
      rdy = f_ready;
      @(posedge clk_a);
      if (rdy) begin
        f_q.push_back(d);
        ok = 1'b1;
      end
      @(negedge clk_a);
    end
    if (!ok) chk("fast_push_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    for (int t = 0; t < budget && busy; t++) @(negedge clk_a);
    chk("idle_reached", 32'(busy), 32'd0);
  endtask

  // Main monitor: launch data vs scoreboard, setup/hold/gap stability, pulse width, period.
  logic [3:0] prev_d, held_d;
  logic       prev_en;
  int         gap_left, cyc, last_rise;
  bit         have_prev;
  initial begin
    prev_en = 1'b0; prev_d = 4'd0; held_d = 4'd0;
    gap_left = 0; cyc = 0; last_rise = 0; have_prev = 1'b0;
    forever begin
      @(negedge clk_a);
      cyc++;
      if (!arstn) begin
        prev_en = 1'b0; prev_d = data_out; gap_left = 0; have_prev = 1'b0;
      end else begin
        if (data_en && !prev_en) begin
          n_launch++;
          if (exp_q.size() != 0) chk("launch_data", 32'(data_out), 32'(exp_q.pop_front()));
          else begin
            n_vec++; n_err++;
            $display("FAIL spurious_launch: launched %0h, scoreboard empty", data_out);
          end
          chk("setup_stable", 32'(data_out), 32'(prev_d));
          if (chk_period && have_prev) chk("launch_period", 32'(cyc - last_rise), 32'd7);
          have_prev = chk_period;
          last_rise = cyc;
          held_d    = data_out;
        end else if (data_en) begin
          chk("hold_stable", 32'(data_out), 32'(held_d));
        end
        if (!data_en && prev_en) begin
          chk("pulse_width", 32'(cyc - last_rise), 32'd4);
          gap_left = 2;
        end
        if (!data_en && gap_left > 0) begin
          chk("gap_stable", 32'(data_out), 32'(held_d));
          gap_left--;
        end
        if (!chk_period) have_prev = 1'b0;
        prev_en = data_en;
        prev_d  = data_out;
      end
    end
  end

  // Fast-instance monitor: 1-cycle pulse, 3-cycle launch period, in-order data.
  logic f_prev_en;
  int   f_cyc, f_last_rise;
  bit   f_have_prev;
  initial begin
    f_prev_en = 1'b0; f_cyc = 0; f_last_rise = 0; f_have_prev = 1'b0;
    forever begin
      @(negedge clk_a);
      f_cyc++;
      if (!arstn) begin
        f_prev_en = 1'b0; f_have_prev = 1'b0;
      end else begin
        if (f_en && !f_prev_en) begin
          if (f_q.size() != 0) chk("fast_launch_data", 32'(f_out), 32'(f_q.pop_front()));
          else begin
            n_vec++; n_err++;
            $display("FAIL fast_spurious_launch: launched %0h, scoreboard empty", f_out);
          end
          if (f_have_prev) chk("fast_period", 32'(f_cyc - f_last_rise), 32'd3);
          f_have_prev = 1'b1;
          f_last_rise = f_cyc;
        end
        if (!f_en && f_prev_en) chk("fast_pulse_width", 32'(f_cyc - f_last_rise), 32'd1);
        f_prev_en = f_en;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         w, nl;
    logic [7:0] en_tab, busy_tab;
    arstn = 1'b0; in_valid = 1'b0; in_data = 4'd0; f_valid = 1'b0; f_data = 4'd0;

    // Reset state
    repeat (3) @(negedge clk_a);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_data_en",  32'(data_en),  32'd0);
    chk("rst_level",    32'(level),    32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_sent_cnt", 32'(sent_cnt), 32'd0);
    #2 arstn = 1'b1;
    @(negedge clk_a);

    // Single word 4'hA: data_out from edge 1, data_en high after edges 2..5, idle at edge 8
    en_tab   = 8'b0001_1110;
    busy_tab = 8'b0111_1111;
    push_a(4'hA, w);
    in_valid = 1'b0;
    chk("single_level", 32'(level), 32'd1);
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk_a);
      chk("single_data_out", 32'(data_out), 32'hA);
      chk("single_data_en",  32'(data_en),  32'(en_tab[e-1]));
      chk("single_busy",     32'(busy),     32'(busy_tab[e-1]));
    end
    chk("single_sent_cnt", 32'(sent_cnt), 32'd1);

    // Burst with in_valid held: first pop overlaps the pushes, so word 6 hits a full FIFO
    chk_period = 1'b1;
    nl = n_launch;
    for (int k = 1; k <= 5; k++) begin
      push_a(4'(k), w);
      chk("burst_no_stall", 32'(w), 32'd0);
    end
    chk("burst_full_level", 32'(level),    32'd4);
    chk("burst_not_ready",  32'(in_ready), 32'd0);
    push_a(4'd6, w);
    chk("burst_stall_cycles", 32'(w), 32'd4);
    in_valid = 1'b0;
    wait_idle(200);
    chk_period = 1'b0;
    chk("burst_launches", 32'(n_launch - nl), 32'd6);
    chk("burst_sent_cnt", 32'(sent_cnt), 32'd7);

    // HOLD=1, GAP=1 instance under continuous input
    for (int i = 0; i < 10; i++) push_f(4'(i + 3));
    f_valid = 1'b0;
    for (int t = 0; t < 100 && f_busy; t++) @(negedge clk_a);
    chk("fast_idle",     32'(f_busy), 32'd0);
    chk("fast_sent_cnt", 32'(f_sent), 32'd10);
    chk("fast_drained",  32'(f_q.size()), 32'd0);

    // Reset during HOLD with two words still queued
    push_a(4'h7, w);
    push_a(4'h8, w);
    push_a(4'h9, w);
    in_valid = 1'b0;
    for (int t = 0; t < 20 && !data_en; t++) @(negedge clk_a);
    chk("pre_reset_en",    32'(data_en), 32'd1);
    chk("pre_reset_level", 32'(level),   32'd2);
    @(negedge clk_a);
    #2 arstn = 1'b0;
    #1;
    chk("async_rst_en",       32'(data_en),  32'd0);
    chk("async_rst_level",    32'(level),    32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    chk("async_rst_data_out", 32'(data_out), 32'd0);
    chk("async_rst_sent_cnt", 32'(sent_cnt), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk_a);
    #2 arstn = 1'b1;
    nl = n_launch;
    repeat (20) @(negedge clk_a);
    chk("post_rst_no_launch", 32'(n_launch - nl), 32'd0);
    chk("post_rst_busy",      32'(busy),  32'd0);
    chk("post_rst_level",     32'(level), 32'd0);

    // 260 words back-to-back: sent_cnt wraps to 4
    chk_period = 1'b1;
    for (int i = 0; i < 260; i++) push_a(4'((i * 7 + 3) % 16), w);
    in_valid = 1'b0;
    wait_idle(200);
    chk_period = 1'b0;
    chk("wrap_sent_cnt", 32'(sent_cnt), 32'd4);
    chk("wrap_drained",  32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
